// File: rtl/cap_demux_pkg.sv
// Shared sizing and FSM encoding for the capacitor re-compaction stage.
package cap_demux_pkg;

  localparam int unsigned WIDTH         = 2;
  localparam int unsigned CHANNEL_NUM   = 70;
  localparam int unsigned CAPACITOR_NUM = 128;
  localparam int unsigned CIW           = $clog2(CAPACITOR_NUM);
  // ch_cnt must reach CHANNEL_NUM+1 to flag overflow
  localparam int unsigned CCW           = $clog2(CHANNEL_NUM + 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } map_state_t;

endpackage

// File: rtl/cap_map_scan.sv
// Builds the channel-to-lane index map by scanning the active mask one lane per edge.
module cap_map_scan
  import cap_demux_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CAPACITOR_NUM-1:0]     sw,
  output logic [CHANNEL_NUM*CIW-1:0]   map_flat,
  output logic                         run,
  output logic                         remap,
  output logic                         map_busy,
  output logic                         map_err
);

  map_state_t               state, state_nxt;
  logic [CAPACITOR_NUM-1:0] sw_active;
  logic [CIW-1:0]           idx;
  logic [CCW-1:0]           ch_cnt;
  logic [CIW-1:0]           map [CHANNEL_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    remap     = (state != ST_IDLE) && (sw != sw_active);
    case (state)
      ST_IDLE:  state_nxt = ST_SCAN;
      ST_SCAN:  if (idx == CIW'(CAPACITOR_NUM - 1)) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (ch_cnt == CCW'(CHANNEL_NUM)) ? ST_RUN : ST_ERR;
      default:  state_nxt = state;
    endcase
    // a mask change overrides every other transition, including mid-scan
    if (remap) state_nxt = ST_SCAN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_active <= '0;
      idx       <= '0;
      ch_cnt    <= '0;
      map_err   <= 1'b0;
      for (int unsigned k = 0; k < CHANNEL_NUM; k++) map[k] <= '0;
    end else if (state == ST_IDLE || remap) begin
      sw_active <= sw;
      idx       <= '0;
      ch_cnt    <= '0;
      map_err   <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (sw_active[idx]) begin
            if (ch_cnt < CCW'(CHANNEL_NUM)) begin
              for (int unsigned k = 0; k < CHANNEL_NUM; k++)
                if (CCW'(k) == ch_cnt) map[k] <= idx;
              ch_cnt <= ch_cnt + 1'b1;
            end else if (ch_cnt == CCW'(CHANNEL_NUM)) begin
              ch_cnt <= CCW'(CHANNEL_NUM + 1);
            end
          end
          if (idx != CIW'(CAPACITOR_NUM - 1)) idx <= idx + 1'b1;
        end
        ST_CHECK: if (ch_cnt != CCW'(CHANNEL_NUM)) map_err <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    map_flat = '0;
    for (int unsigned k = 0; k < CHANNEL_NUM; k++) map_flat[k*CIW +: CIW] = map[k];
  end

  assign run      = (state == ST_RUN);
  assign map_busy = (state == ST_SCAN) || (state == ST_CHECK);

endmodule

// File: rtl/cap_demux.sv
// Re-packs the active capacitor lanes into channel order on a registered output bus.
module cap_demux
  import cap_demux_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WIDTH*CAPACITOR_NUM-1:0]   cap_in,
  input  logic [CAPACITOR_NUM-1:0]         sw,
  output logic [WIDTH*CHANNEL_NUM-1:0]     data_out,
  output logic                             data_valid,
  output logic                             map_busy,
  output logic                             map_err
);

  logic [CHANNEL_NUM*CIW-1:0]   map_flat;
  logic                         run;
  logic                         remap;
  logic [WIDTH*CHANNEL_NUM-1:0] data_nxt;

  cap_map_scan u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .map_flat (map_flat),
    .run      (run),
    .remap    (remap),
    .map_busy (map_busy),
    .map_err  (map_err)
  );

  always_comb begin
    data_nxt = '0;
    for (int unsigned k = 0; k < CHANNEL_NUM; k++)
      data_nxt[k*WIDTH +: WIDTH] = cap_in[map_flat[k*CIW +: CIW]*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (remap) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (run) begin
      data_out   <= data_nxt;
      data_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cap_demux.sv
// Directed bench for cap_demux: startup/remap latency, error masks, async reset, RUN data.
module tb_cap_demux;
  import cap_demux_pkg::*;

  localparam int unsigned DW = WIDTH*CHANNEL_NUM;
  localparam int unsigned CW = WIDTH*CAPACITOR_NUM;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [CW-1:0]            cap_in;
  logic [CAPACITOR_NUM-1:0] sw;
  logic [DW-1:0]            data_out;
  logic                     data_valid;
  logic                     map_busy;
  logic                     map_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  cap_demux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_in     (cap_in),
    .sw         (sw),
    .data_out   (data_out),
    .data_valid (data_valid),
    .map_busy   (map_busy),
    .map_err    (map_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [CW-1:0] cap;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [6];
  logic [CW-1:0] c;
  int unsigned   n;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // edges until data_valid is seen; 300 means it never rose
  task automatic wait_valid(output int unsigned cnt);
    cnt = 0;
    while (cnt < 300) begin
      step();
      cnt++;
      if (data_valid) break;
    end
  endtask

  function automatic logic [CAPACITOR_NUM-1:0] mask_range(int unsigned lo, int unsigned num);
    logic [CAPACITOR_NUM-1:0] m = '0;
    for (int unsigned i = lo; i < lo + num; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [CW-1:0] cap_mod4();
    logic [CW-1:0] r = '0;
    for (int unsigned i = 0; i < CAPACITOR_NUM; i++) r[i*WIDTH +: WIDTH] = WIDTH'(i % 4);
    return r;
  endfunction

  // expected output when lane i carries i mod 4 and channel k sits on lane k+off
  function automatic logic [DW-1:0] exp_shift(int unsigned off);
    logic [DW-1:0] e = '0;
    for (int unsigned k = 0; k < CHANNEL_NUM; k++) e[k*WIDTH +: WIDTH] = WIDTH'((k + off) % 4);
    return e;
  endfunction

  function automatic logic [DW-1:0] ref_pack(logic [CAPACITOR_NUM-1:0] m, logic [CW-1:0] cp);
    logic [DW-1:0] e = '0;
    int unsigned   k = 0;
    for (int unsigned i = 0; i < CAPACITOR_NUM; i++)
      if (m[i] && k < CHANNEL_NUM) begin
        e[k*WIDTH +: WIDTH] = cp[i*WIDTH +: WIDTH];
        k++;
      end
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    c = cap_mod4();
    vecs[0].name = "mod4";     vecs[0].cap = c;   vecs[0].exp = c[DW-1:0];
    vecs[1].name = "inv_mod4"; vecs[1].cap = ~c;  vecs[1].exp = ~c[DW-1:0];
    vecs[2].name = "zeros";    vecs[2].cap = '0;  vecs[2].exp = '0;
    vecs[3].name = "ones";     vecs[3].cap = '1;  vecs[3].exp = '1;
    c = {8{$urandom()}};
    vecs[4].name = "rand_a";   vecs[4].cap = c;   vecs[4].exp = c[DW-1:0];
    c = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    vecs[5].name = "rand_b";   vecs[5].cap = c;   vecs[5].exp = c[DW-1:0];

    // reset and startup with the lower 70 lanes active
    rst_n  = 1'b0;
    sw     = mask_range(0, 70);
    cap_in = cap_mod4();
    #12;
    check("rst_data",  256'(data_out),   256'(0));
    check("rst_valid", 256'(data_valid), 256'(0));
    check("rst_busy",  256'(map_busy),   256'(0));
    check("rst_err",   256'(map_err),    256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("e1_busy", 256'(map_busy), 256'(1));
    wait_valid(n);
    check("startup_lat", 256'(n), 256'(130));
    check("startup_data", 256'(data_out), 256'(exp_shift(0)));
    check("run_busy", 256'(map_busy), 256'(0));

    // one-edge latency, cap_in changing every cycle
    for (int i = 0; i < 6; i++) begin
      cap_in = vecs[i].cap;
      step();
      check({"vec_", vecs[i].name}, 256'(data_out), 256'(vecs[i].exp));
      check({"vld_", vecs[i].name}, 256'(data_valid), 256'(1));
    end

    // remap to upper 70 lanes
    cap_in = cap_mod4();
    sw     = mask_range(58, 70);
    step();
    check("remap_inval", 256'(data_valid), 256'(0));
    check("remap_zero",  256'(data_out),   256'(0));
    check("remap_busy",  256'(map_busy),   256'(1));
    wait_valid(n);
    check("remap_lat",  256'(n), 256'(130));
    check("upper_data", 256'(data_out), 256'(exp_shift(58)));

    // 69 active lanes: error at the CHECK edge, outputs stay dead
    sw = mask_range(0, 69);
    step();
    repeat (128) step();
    check("err69_early", 256'(map_err), 256'(0));
    step();
    check("err69_set", 256'(map_err), 256'(1));
    repeat (40) step();
    check("err69_hold",  256'(map_err),    256'(1));
    check("err69_valid", 256'(data_valid), 256'(0));
    check("err69_data",  256'(data_out),   256'(0));
    check("err69_busy",  256'(map_busy),   256'(0));

    // 71 active lanes, then recovery to a legal mask
    sw = mask_range(0, 71);
    repeat (130) step();
    check("err71_set", 256'(map_err), 256'(1));
    check("err71_valid", 256'(data_valid), 256'(0));
    sw = mask_range(1, 70);
    step();
    check("err_clear", 256'(map_err), 256'(0));
    wait_valid(n);
    check("recover_lat",  256'(n), 256'(130));
    check("recover_data", 256'(data_out), 256'(exp_shift(1)));

    // abort a scan partway through: only the newest mask may be used
    sw = mask_range(58, 70);
    step();
    repeat (48) step();
    check("abort_busy", 256'(map_busy), 256'(1));
    sw = mask_range(20, 70);
    step();
    check("abort_valid", 256'(data_valid), 256'(0));
    wait_valid(n);
    check("abort_lat",  256'(n), 256'(130));
    check("abort_data", 256'(data_out), 256'(exp_shift(20)));

    // asynchronous reset between edges in RUN
    cap_in = {8{$urandom()}};
    step();
    check("pre_rst_data", 256'(data_out), 256'(ref_pack(sw, cap_in)));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data",  256'(data_out),   256'(0));
    check("arst_valid", 256'(data_valid), 256'(0));
    check("arst_busy",  256'(map_busy),   256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    check("restart_lat",  256'(n), 256'(131));
    check("restart_data", 256'(data_out), 256'(ref_pack(sw, cap_in)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
